bias_relu_stage: RTL and testbench

//   Parametrised post-convolution bias stage that replaces per-layer hard-coded bias ROMs.

---
 rtl/bias_relu_stage.sv | 125 ++++++++++++
 tb/tb_bias_relu_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_relu_stage.sv
// Post-convolution bias stage: per-channel run-time bias add, round/shift,
// optional ReLU and saturation, with ready/valid flow control.
`timescale 1ns/1ps
module bias_relu_stage #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned BIAS_W  = 32,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned NUM_CH  = 32,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned RELU_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bias_wr_en,
  input  logic [$clog2(NUM_CH)-1:0] bias_wr_addr,
  input  logic [BIAS_W-1:0]         bias_wr_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ACC_W-1:0]          in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last,
  output logic                      err_misalign,
  output logic [15:0]               sat_cnt
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned S1_W   = ACC_W + 1;
  localparam int unsigned S2_W   = ACC_W + 2;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [CH_W-1:0]        LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [S2_W-1:0] RND     = (SHIFT > 0) ? (S2_W'(1) << RND_SH) : '0;
  localparam logic signed [S2_W-1:0] MAX_V   = {{(S2_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [S2_W-1:0] MIN_V   = {{(S2_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [BIAS_W-1:0]        bias_q [NUM_CH];
  logic [BIAS_W-1:0]        bias_sel;
  logic [CH_W-1:0]          ch_q;
  logic                     adv;
  logic                     accept;

  logic                     s1_valid;
  logic signed [S1_W-1:0]   s1_sum;
  logic [CH_W-1:0]          s1_ch;
  logic                     s1_last;

  logic signed [S2_W-1:0]   s2_wide;
  logic signed [S2_W-1:0]   s2_shift;
  logic signed [S2_W-1:0]   s2_relu;
  logic                     s2_sat;
  logic [OUT_W-1:0]         s2_data;

  // Both stages advance together; a stalled output freezes the whole pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign bias_sel = bias_q[ch_q];

  // Round half up, shift, ReLU and clamp, all at ACC_W+2 so nothing wraps.
  always_comb begin
    s2_wide  = {s1_sum[S1_W-1], s1_sum};
    s2_shift = (s2_wide + RND) >>> SHIFT;
    s2_relu  = s2_shift;
    if (RELU_EN != 0 && s2_shift < 0) s2_relu = '0;
    s2_sat   = 1'b0;
    s2_data  = s2_relu[OUT_W-1:0];
    if (s2_relu > MAX_V) begin
      s2_sat  = 1'b1;
      s2_data = MAX_V[OUT_W-1:0];
    end else if (s2_relu < MIN_V) begin
      s2_sat  = 1'b1;
      s2_data = MIN_V[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) bias_q[i] <= '0;
      ch_q         <= '0;
      err_misalign <= 1'b0;
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      s1_ch        <= '0;
      s1_last      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
      out_last     <= 1'b0;
      sat_cnt      <= '0;
    end else begin
      if (bias_wr_en) bias_q[bias_wr_addr] <= bias_wr_data;

      // A premature in_last realigns the counter to the next pixel start.
      if (accept) begin
        if (in_last && ch_q != LAST_CH) begin
          err_misalign <= 1'b1;
          ch_q         <= '0;
        end else if (ch_q == LAST_CH) begin
          ch_q <= '0;
        end else begin
          ch_q <= ch_q + CH_W'(1);
        end
      end

      if (adv) begin
        s1_valid  <= in_valid;
        s1_sum    <= $signed({in_data[ACC_W-1], in_data})
                   + $signed({{(S1_W-BIAS_W){bias_sel[BIAS_W-1]}}, bias_sel});
        s1_ch     <= ch_q;
        s1_last   <= in_last;
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s2_data;
          out_ch   <= s1_ch;
          out_last <= s1_last;
          if (s2_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bias_relu_stage.sv
// Randomized bench for bias_relu_stage: three parameter variants share one
// stimulus stream and are checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bias_relu_stage;

  localparam int unsigned NUM_CH = 32;
  localparam int N_DUT = 3;

  logic clk, rst;
  logic bias_wr_en;
  logic [4:0]  bias_wr_addr;
  logic [31:0] bias_wr_data;
  logic in_valid, in_last, out_ready;
  logic [31:0] in_data;

  logic        rdy  [N_DUT];
  logic        ov   [N_DUT];
  logic [15:0] od   [N_DUT];
  logic [4:0]  och  [N_DUT];
  logic        olst [N_DUT];
  logic        oerr [N_DUT];
  logic [15:0] osat [N_DUT];

  int n_chk = 0;
  int n_fail = 0;
  int bp_mode = 0;

  typedef struct { longint sum; int ch; bit last; } beat_t;
  beat_t  q[$];
  longint mbias [NUM_CH];
  int     mch;
  bit     merr;
  int     msat [N_DUT];
  bit     prev_stall;
  logic [15:0] pd [N_DUT];
  logic [4:0]  pc [N_DUT];
  logic        pl [N_DUT];

  bias_relu_stage #(.SHIFT(0), .RELU_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
    .bias_wr_data(bias_wr_data), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_ch(och[0]), .out_last(olst[0]), .err_misalign(oerr[0]), .sat_cnt(osat[0]));
  bias_relu_stage #(.SHIFT(8), .RELU_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
    .bias_wr_data(bias_wr_data), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_ch(och[1]), .out_last(olst[1]), .err_misalign(oerr[1]), .sat_cnt(osat[1]));
  bias_relu_stage #(.SHIFT(8), .RELU_EN(0)) u_dut2 (
    .clk(clk), .rst(rst), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
    .bias_wr_data(bias_wr_data), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_ch(och[2]), .out_last(olst[2]), .err_misalign(oerr[2]), .sat_cnt(osat[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cfg_shift(input int i);
    return (i == 0) ? 0 : 8;
  endfunction

  function automatic bit cfg_relu(input int i);
    return (i == 1);
  endfunction

  // Reference result: floor((sum + half) / 2^shift), ReLU, clamp to 16 bits.
  task automatic model_out(input longint sum, input int i, output longint val, output bit sat);
    longint n, d, r;
    int sh;
    sh = cfg_shift(i);
    r = sum;
    if (sh > 0) begin
      d = longint'(1) << sh;
      n = sum + d / 2;
      r = n / d;
      if (n < 0 && (n % d) != 0) r = r - 1;
    end
    if (cfg_relu(i) && r < 0) r = 0;
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    val = r;
  endtask

  // Output-ready pattern generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    longint v;
    bit s;
    beat_t e;
    if (rst) begin
      q.delete();
      for (int c = 0; c < int'(NUM_CH); c++) mbias[c] = 0;
      mch = 0;
      merr = 1'b0;
      for (int i = 0; i < N_DUT; i++) msat[i] = 0;
      prev_stall = 1'b0;
    end else begin
      for (int i = 0; i < N_DUT; i++) begin
        chk("err_misalign", longint'(oerr[i]), longint'(merr));
        chk("in_ready", longint'(rdy[i]), longint'(!ov[i] || out_ready));
        chk("valid_agree", longint'(ov[i]), longint'(ov[0]));
        if (prev_stall) begin
          chk("stall_valid", longint'(ov[i]), 1);
          chk("stall_data", longint'(od[i]), longint'(pd[i]));
          chk("stall_ch", longint'(och[i]), longint'(pc[i]));
          chk("stall_last", longint'(olst[i]), longint'(pl[i]));
        end
      end
      if (ov[0]) begin
        if (q.size() == 0) chk("spurious_valid", 1, 0);
        else if (out_ready) begin
          e = q.pop_front();
          for (int i = 0; i < N_DUT; i++) begin
            model_out(e.sum, i, v, s);
            if (s && msat[i] < 65535) msat[i]++;
            chk("out_data", longint'($signed(od[i])), v);
            chk("out_ch", longint'(och[i]), longint'(e.ch));
            chk("out_last", longint'(olst[i]), longint'(e.last));
            chk("sat_cnt", longint'(osat[i]), longint'(msat[i]));
          end
        end
      end
      prev_stall = ov[0] && !out_ready;
      for (int i = 0; i < N_DUT; i++) begin
        pd[i] = od[i]; pc[i] = och[i]; pl[i] = olst[i];
      end
      // Accepted beat uses the bias as it stands before this cycle's write.
      if (in_valid && rdy[0]) begin
        e.sum  = longint'($signed(in_data)) + mbias[mch];
        e.ch   = mch;
        e.last = in_last;
        q.push_back(e);
        if (in_last && mch != int'(NUM_CH) - 1) begin
          merr = 1'b1;
          mch = 0;
        end else begin
          mch = (mch + 1) % int'(NUM_CH);
        end
      end
      if (bias_wr_en) mbias[bias_wr_addr] = longint'($signed(bias_wr_data));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input longint data, input bit last);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = 32'(data);
    in_last  = last;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = rdy[0];
      tick();
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wr_bias(input int addr, input longint val);
    bias_wr_en   = 1'b1;
    bias_wr_addr = 5'(addr);
    bias_wr_data = 32'(val);
    tick();
    bias_wr_en   = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain", longint'(q.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single beat into an empty pipe with out_ready high: latency and literal results.
  task automatic one_beat(input longint data, input longint e0, input longint e1, input longint e2);
    longint exp_v [N_DUT];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
    drive_beat(data, 1'b0);
    idle();
    for (int i = 0; i < N_DUT; i++) chk("latency_1", longint'(ov[i]), 0);
    tick();
    for (int i = 0; i < N_DUT; i++) begin
      chk("latency_2", longint'(ov[i]), 1);
      chk("beat_value", longint'($signed(od[i])), exp_v[i]);
    end
  endtask

  initial begin
    int ch;
    rst = 1'b1;
    bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < N_DUT; i++) begin
      chk("rst_valid", longint'(ov[i]), 0);
      chk("rst_data", longint'(od[i]), 0);
      chk("rst_ch", longint'(och[i]), 0);
      chk("rst_last", longint'(olst[i]), 0);
      chk("rst_err", longint'(oerr[i]), 0);
      chk("rst_sat", longint'(osat[i]), 0);
    end
    rst = 1'b0;
    tick();

    // Bias add over one full pixel.
    wr_bias(0, -91); wr_bias(1, 145); wr_bias(2, 164); wr_bias(3, -300);
    one_beat(100, 9, 0, 0);
    for (int c = 1; c < int'(NUM_CH); c++) drive_beat(100, c == int'(NUM_CH) - 1);
    drain();

    // Rounding, ReLU and saturation with zero bias.
    do_reset();
    one_beat(384, 384, 2, 2);
    one_beat(383, 383, 1, 1);
    one_beat(-384, -384, 0, -1);
    for (int i = 0; i < N_DUT; i++) chk("sat_none", longint'(osat[i]), 0);
    one_beat(longint'(32'h7FFF_0000), 32767, 32767, 32767);
    chk("sat_hi0", longint'(osat[0]), 1);
    chk("sat_hi1", longint'(osat[1]), 1);
    chk("sat_hi2", longint'(osat[2]), 1);
    one_beat(-longint'(32'h8000_0000), -32768, 0, -32768);
    chk("sat_lo0", longint'(osat[0]), 2);
    chk("sat_lo1", longint'(osat[1]), 1);
    chk("sat_lo2", longint'(osat[2]), 2);
    drain();

    // Alternating backpressure.
    do_reset();
    bp_mode = 1;
    for (int k = 0; k < 8; k++) drive_beat(longint'($urandom_range(0, 100000)) - 50000, 1'b0);
    drain();
    bp_mode = 0;

    // Premature in_last, then realignment.
    do_reset();
    for (int c = 0; c < 6; c++) drive_beat(1000 + c, c == 5);
    drain();
    for (int i = 0; i < N_DUT; i++) chk("misalign_set", longint'(oerr[i]), 1);
    for (int c = 0; c < 4; c++) drive_beat(2000 + c, 1'b0);
    drain();
    for (int i = 0; i < N_DUT; i++) chk("misalign_sticky", longint'(oerr[i]), 1);

    // Reset with beats in flight.
    bp_mode = 2;
    for (int k = 0; k < 6; k++) drive_beat(longint'($urandom_range(0, 5000)), 1'b0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < N_DUT; i++) chk("rst_flush", longint'(ov[i]), 0);
    rst = 1'b0;
    idle();
    bp_mode = 0;
    tick();
    tick();
    one_beat(55, 55, 0, 0);
    chk("rst_ch_restart", longint'(och[0]), 0);
    drain();

    // Bias write colliding with the accept of the same channel.
    do_reset();
    wr_bias(3, 7);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (p == 0 && c == 3) begin
          bias_wr_en = 1'b1; bias_wr_addr = 5'd3; bias_wr_data = 32'd50;
        end
        drive_beat(100, c == int'(NUM_CH) - 1);
        bias_wr_en = 1'b0;
      end
    end
    drain();

    // Random traffic, random biases and random backpressure.
    bp_mode = 2;
    ch = 0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        bias_wr_en   = 1'b1;
        bias_wr_addr = 5'($urandom_range(0, NUM_CH - 1));
        bias_wr_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
      end
      if ($urandom_range(0, 5) == 0) begin
        idle();
        tick();
      end
      if ($urandom_range(0, 2) == 0) drive_beat(longint'($signed($urandom)), ch == int'(NUM_CH) - 1);
      else drive_beat(longint'($urandom_range(0, 400000)) - 200000, ch == int'(NUM_CH) - 1);
      bias_wr_en = 1'b0;
      ch = (ch + 1) % int'(NUM_CH);
    end
    drain();
    bp_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
